// File: rtl/stack_address_unit.sv
// stack_address_unit
// Registered program counter plus one downward-growing stack pointer per
// execution context (context 0 is kernel). PUSH/POP commands, single or
// multi-word, are accepted from the control unit and turned into a sequence
// of data-memory beats. Range checks are all-or-nothing at acceptance.
//
// Handshake rules (both ports are strict valid/ready):
//   - Command port: a command transfers on the rising edge where
//     cmd_valid && cmd_ready. cmd_ready is high only while the FSM is IDLE.
//   - Memory port: a beat transfers on the rising edge where
//     mem_valid && mem_ready. While mem_ready is low, mem_valid,
//     mem_write and output_address hold stable; the SP moves only when a
//     beat transfers.
module stack_address_unit #(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_CONTEXTS = 2,
    parameter int CTX_WIDTH    = 1,
    parameter int STACK_BASE   = 4096,
    parameter int STACK_DEPTH  = 2048,
    parameter int LEN_WIDTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            control,
    input  logic [CTX_WIDTH-1:0]  context_id,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [ADDR_WIDTH-1:0] input_address,
    input  logic                  pc_enable,
    input  logic                  should_branch,
    output logic                  mem_valid,
    output logic                  mem_write,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] output_address,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [ADDR_WIDTH-1:0] current_SP,
    output logic                  overflow,
    output logic                  underflow,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1
    } state_t;

    localparam logic [2:0] OP_PUSH       = 3'd1;
    localparam logic [2:0] OP_POP        = 3'd2;
    localparam logic [2:0] OP_SP_LOAD    = 3'd3;
    localparam logic [2:0] OP_PUSH_MULTI = 3'd4;
    localparam logic [2:0] OP_POP_MULTI  = 3'd5;
    localparam logic [2:0] OP_SP_CLEAR   = 3'd6;

    localparam logic [CTX_WIDTH:0] NUM_CTX_W = (CTX_WIDTH+1)'(NUM_CONTEXTS);

    // Lowest legal stack address of context i.
    function automatic logic [ADDR_WIDTH-1:0] ctx_lo(input int i);
        return ADDR_WIDTH'(STACK_BASE + i * STACK_DEPTH);
    endfunction

    // SP value of an empty stack for context i (one above the top word).
    function automatic logic [ADDR_WIDTH-1:0] ctx_empty(input int i);
        return ADDR_WIDTH'(STACK_BASE + (i + 1) * STACK_DEPTH);
    endfunction

    state_t                state;
    logic [ADDR_WIDTH-1:0] sp [NUM_CONTEXTS];
    logic [ADDR_WIDTH-1:0] pc;
    logic [CTX_WIDTH-1:0]  ctx_q;
    logic                  push_q;
    logic [LEN_WIDTH-1:0]  remaining;

    logic                  ctx_ok;
    logic                  accept;
    logic                  beat_done;
    logic                  is_push_cmd;
    logic                  is_pop_cmd;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic [ADDR_WIDTH-1:0] len_ext;
    logic [ADDR_WIDTH-1:0] sel_sp;
    logic [ADDR_WIDTH-1:0] cur_lo;
    logic [ADDR_WIDTH-1:0] cur_empty;
    logic [ADDR_WIDTH-1:0] free_words;
    logic [ADDR_WIDTH-1:0] used_words;
    logic                  push_too_big;
    logic                  pop_too_big;
    logic [ADDR_WIDTH-1:0] burst_sp;
    logic [ADDR_WIDTH-1:0] beat_addr;

    // Command decode, per-context limits and range check for the IDLE command.
    always_comb begin
        ctx_ok      = ({1'b0, context_id} < NUM_CTX_W);
        accept      = cmd_valid && cmd_ready;
        beat_done   = mem_valid && mem_ready;
        is_push_cmd = (control == OP_PUSH) || (control == OP_PUSH_MULTI);
        is_pop_cmd  = (control == OP_POP)  || (control == OP_POP_MULTI);
        eff_len     = '0;
        if ((control == OP_PUSH) || (control == OP_POP)) begin
            eff_len = LEN_WIDTH'(1);
        end else if ((control == OP_PUSH_MULTI) || (control == OP_POP_MULTI)) begin
            eff_len = burst_len;
        end
        len_ext   = ADDR_WIDTH'(eff_len);
        sel_sp    = ctx_ok ? sp[context_id] : '0;
        cur_lo    = ctx_lo(int'(context_id));
        cur_empty = ctx_empty(int'(context_id));
        // An SP_LOAD may place the SP outside its window; clamp so the
        // subtractions below never wrap into a huge free/used count.
        free_words   = (sel_sp > cur_lo)    ? (sel_sp - cur_lo)    : '0;
        used_words   = (sel_sp < cur_empty) ? (cur_empty - sel_sp) : '0;
        push_too_big = len_ext > free_words;
        pop_too_big  = len_ext > used_words;
    end

    // Memory-side address: the active beat while bursting, pass-through otherwise.
    always_comb begin
        burst_sp       = sp[ctx_q];
        beat_addr      = push_q ? (burst_sp - ADDR_WIDTH'(1)) : burst_sp;
        output_address = (state == ST_BURST) ? beat_addr : input_address;
        current_SP     = (state == ST_BURST) ? burst_sp : sel_sp;
        cmd_ready      = (state == ST_IDLE);
        fsm_state      = state;
    end

    // Program counter: increments or branches whenever enabled, independent of the stack FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= PC_RESET;
        end else if (pc_enable) begin
            pc <= should_branch ? input_address : (pc + ADDR_WIDTH'(1));
        end
    end

    assign instruction_address = pc;

    // Stack FSM: command acceptance, range rejection, beat sequencing and SP updates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ctx_q     <= '0;
            push_q    <= 1'b0;
            remaining <= '0;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < NUM_CONTEXTS; i++) begin
                sp[i] <= ctx_empty(i);
            end
        end else begin
            // Fault flags are single-cycle pulses.
            overflow  <= 1'b0;
            underflow <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && ctx_ok) begin
                        if (is_push_cmd || is_pop_cmd) begin
                            // Zero length is accepted and does nothing.
                            if (eff_len != '0) begin
                                if (is_push_cmd && push_too_big) begin
                                    overflow <= 1'b1;
                                end else if (is_pop_cmd && pop_too_big) begin
                                    underflow <= 1'b1;
                                end else begin
                                    state     <= ST_BURST;
                                    ctx_q     <= context_id;
                                    push_q    <= is_push_cmd;
                                    remaining <= eff_len;
                                    mem_valid <= 1'b1;
                                    mem_write <= is_push_cmd;
                                end
                            end
                        end else if (control == OP_SP_LOAD) begin
                            sp[context_id] <= input_address;
                        end else if (control == OP_SP_CLEAR) begin
                            sp[context_id] <= cur_empty;
                        end
                    end
                end
                ST_BURST: begin
                    if (beat_done) begin
                        sp[ctx_q] <= push_q ? (burst_sp - ADDR_WIDTH'(1))
                                            : (burst_sp + ADDR_WIDTH'(1));
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state     <= ST_IDLE;
                            mem_valid <= 1'b0;
                            mem_write <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_valid <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
